// File: rtl/voice_allocator.sv
// Polyphonic voice allocator.
// Maps note-on/note-off events onto a fixed pool of envelope/oscillator voices.
// Each voice is FREE, HELD or RELEASING and carries a note and an age. Note-ons
// prefer a retrigger, then a free voice, then the oldest releasing voice, and
// finally the oldest held voice.
//
// Event handshake: an event transfers on a rising edge where event_valid and
// event_ready are both high. event_ready is high only while the control FSM is
// in IDLE and panic is low. event_is_on and event_note are captured on that
// edge. The source may change them freely afterwards.
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_WIDTH = 7,
  parameter int AGE_WIDTH  = 4
) (
  input  logic                             clock_50_000_000,
  input  logic                             reset_l,
  input  logic                             event_valid,
  output logic                             event_ready,
  input  logic                             event_is_on,
  input  logic [NOTE_WIDTH-1:0]            event_note,
  input  logic                             panic,
  input  logic [NUM_VOICES-1:0]            voice_envelope_end,
  output logic [NUM_VOICES-1:0]            voice_note_on,
  output logic [NUM_VOICES-1:0]            voice_note_off,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
  output logic [NUM_VOICES-1:0]            voice_active,
  output logic                             steal,
  output logic [1:0]                       dbg_state
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;

  localparam logic [1:0] V_FREE = 2'd0;
  localparam logic [1:0] V_HELD = 2'd1;
  localparam logic [1:0] V_REL  = 2'd2;

  logic [1:0]            r_state;
  logic                  r_is_on;
  logic [NOTE_WIDTH-1:0] r_note;
  logic [IDX_W-1:0]      r_target;
  logic                  r_hit;
  logic [NUM_VOICES-1:0] r_note_on;
  logic [NUM_VOICES-1:0] r_note_off;
  logic                  r_steal;

  logic [1:0]            r_vstate [NUM_VOICES];
  logic [NOTE_WIDTH-1:0] r_vnote  [NUM_VOICES];
  logic [AGE_WIDTH-1:0]  r_vage   [NUM_VOICES];

  logic                  w_retrig_hit, w_free_hit, w_rel_hit, w_held_hit, w_off_hit;
  logic [IDX_W-1:0]      w_retrig_idx, w_free_idx, w_rel_idx, w_held_idx, w_off_idx;
  logic [AGE_WIDTH-1:0]  w_rel_age, w_held_age;
  logic [IDX_W-1:0]      w_target;
  logic                  w_hit;
  logic                  w_steal;
  logic [NUM_VOICES-1:0] w_onehot;
  logic [NUM_VOICES-1:0] w_held_mask;
  logic                  w_issue;

  assign event_ready    = (r_state == S_IDLE) && !panic;
  assign voice_note_on  = r_note_on;
  assign voice_note_off = r_note_off;
  assign steal          = r_steal;
  assign dbg_state      = r_state;
  assign w_onehot       = {{(NUM_VOICES-1){1'b0}}, 1'b1} << w_target;
  assign w_issue        = (r_state == S_ISSUE) && r_hit;

  // Candidate search over registered voice state; ascending scan so ties go to the lowest index.
  always_comb begin
    w_retrig_hit = 1'b0; w_retrig_idx = '0;
    w_free_hit   = 1'b0; w_free_idx   = '0;
    w_rel_hit    = 1'b0; w_rel_idx    = '0; w_rel_age  = '0;
    w_held_hit   = 1'b0; w_held_idx   = '0; w_held_age = '0;
    w_off_hit    = 1'b0; w_off_idx    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!w_retrig_hit && r_vstate[i] != V_FREE && r_vnote[i] == r_note) begin
        w_retrig_hit = 1'b1;
        w_retrig_idx = IDX_W'(i);
      end
      if (!w_free_hit && r_vstate[i] == V_FREE) begin
        w_free_hit = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_vstate[i] == V_REL && (!w_rel_hit || r_vage[i] > w_rel_age)) begin
        w_rel_hit = 1'b1;
        w_rel_idx = IDX_W'(i);
        w_rel_age = r_vage[i];
      end
      if (r_vstate[i] == V_HELD && (!w_held_hit || r_vage[i] > w_held_age)) begin
        w_held_hit = 1'b1;
        w_held_idx = IDX_W'(i);
        w_held_age = r_vage[i];
      end
      if (!w_off_hit && r_vstate[i] == V_HELD && r_vnote[i] == r_note) begin
        w_off_hit = 1'b1;
        w_off_idx = IDX_W'(i);
      end
    end
  end

  // Target choice: retrigger, then free, then steal oldest releasing, then steal oldest held.
  always_comb begin
    w_target = '0;
    w_hit    = 1'b0;
    w_steal  = 1'b0;
    if (r_is_on) begin
      w_hit = 1'b1;
      if (w_retrig_hit) begin
        w_target = w_retrig_idx;
      end else if (w_free_hit) begin
        w_target = w_free_idx;
      end else if (w_rel_hit) begin
        w_target = w_rel_idx;
        w_steal  = 1'b1;
      end else begin
        w_target = w_held_idx;
        w_steal  = 1'b1;
      end
    end else begin
      w_hit    = w_off_hit;
      w_target = w_off_idx;
    end
  end

  // Per-voice views: held mask for panic, active flags and the packed note bus.
  always_comb begin
    w_held_mask  = '0;
    voice_active = '0;
    voice_note   = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_held_mask[i]  = (r_vstate[i] == V_HELD);
      voice_active[i] = (r_vstate[i] != V_FREE);
      voice_note[i*NOTE_WIDTH +: NOTE_WIDTH] = r_vnote[i];
    end
  end

  // Control FSM; the pulse registers are loaded at the LOOKUP edge so they are visible during ISSUE.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      r_state    <= S_IDLE;
      r_is_on    <= 1'b0;
      r_note     <= '0;
      r_target   <= '0;
      r_hit      <= 1'b0;
      r_note_on  <= '0;
      r_note_off <= '0;
      r_steal    <= 1'b0;
    end else begin
      r_note_on  <= '0;
      r_note_off <= '0;
      r_steal    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (event_valid && event_ready) begin
            r_is_on <= event_is_on;
            r_note  <= event_note;
            r_state <= S_LOOKUP;
          end else if (panic) begin
            r_note_off <= w_held_mask;
          end
        end
        S_LOOKUP: begin
          r_target <= w_target;
          r_hit    <= w_hit;
          r_steal  <= w_steal;
          if (w_hit && r_is_on) r_note_on <= w_onehot;
          if (w_hit && !r_is_on) r_note_off <= w_onehot;
          r_state  <= S_ISSUE;
        end
        S_ISSUE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Voice state: the issued event owns its target voice; envelope end, panic and ageing act on the rest.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_vstate[i] <= V_FREE;
        r_vnote[i]  <= '0;
        r_vage[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (w_issue && IDX_W'(i) == r_target) begin
          if (r_is_on) begin
            r_vstate[i] <= V_HELD;
            r_vnote[i]  <= r_note;
            r_vage[i]   <= '0;
          end else begin
            r_vstate[i] <= V_REL;
          end
        end else begin
          if (r_vstate[i] == V_REL && voice_envelope_end[i]) r_vstate[i] <= V_FREE;
          if (r_state == S_IDLE && panic && r_vstate[i] == V_HELD) r_vstate[i] <= V_REL;
          if (w_issue && r_is_on && r_vstate[i] != V_FREE && r_vage[i] != {AGE_WIDTH{1'b1}})
            r_vage[i] <= r_vage[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 8, number of envelope/oscillator voices managed (2..16).
REQ-002 Parameter NOTE_WIDTH, default 7, MIDI note number width.
REQ-003 Parameter AGE_WIDTH, default 4, per-voice age counter width.
REQ-004 clock_50_000_000  input  1  system clock; all state changes on its rising edge.
REQ-005 reset_l  input  1  reset, asynchronous, active-low.
REQ-006 event_valid  input  1  note event presented.
REQ-007 event_ready  output  1  allocator can accept an event.
REQ-008 event_is_on  input  1  1 = note-on, 0 = note-off.
REQ-009 event_note  input  NOTE_WIDTH  note number of the event.
REQ-010 panic  input  1  all-notes-off request, level-sampled.
REQ-011 voice_envelope_end  input  NUM_VOICES  per-voice one-cycle pulse from the envelope at release completion.
REQ-012 voice_note_on  output  NUM_VOICES  per-voice one-cycle gate-on pulse, at most one bit set.
REQ-013 voice_note_off  output  NUM_VOICES  per-voice one-cycle gate-off pulse.
REQ-014 voice_note  output  NUM_VOICES*NOTE_WIDTH  registered note per voice; voice i occupies bits [i*NOTE_WIDTH +: NOTE_WIDTH].
REQ-015 voice_active  output  NUM_VOICES  voice state is not FREE.
REQ-016 steal  output  1  one-cycle pulse when a note-on pre-empts a busy voice.

Function
REQ-017 Each voice SHALL hold a state FREE, HELD or RELEASING, plus a note and an age.
REQ-018 Control FSM: IDLE -> LOOKUP -> ISSUE -> IDLE; event_ready SHALL be 1 exactly in IDLE with panic low.
REQ-019 Handshake: an event SHALL be accepted on a cycle with event_valid & event_ready, with is_on and note registered; the FSM SHALL then enter LOOKUP.
REQ-020 LOOKUP SHALL select the target voice from registered voice state; ISSUE SHALL drive the output pulses, so pulses appear exactly 2 cycles after acceptance.
REQ-021 Note-on target priority: (a) the lowest-index non-FREE voice whose note equals event_note (retrigger); else (b) the lowest-index FREE voice; else (c) the RELEASING voice with the largest age; else (d) the HELD voice with the largest age; age ties go to the lowest index.
REQ-022 Note-on in ISSUE SHALL pulse voice_note_on[target], set the target to HELD, load its note, and set its age to 0.
REQ-023 Note-on in ISSUE SHALL increment every other non-FREE voice's age, saturating at 2^AGE_WIDTH-1.
REQ-024 steal SHALL pulse in ISSUE only for cases (c) and (d).
REQ-025 Note-off SHALL target the lowest-index HELD voice with a matching note; in ISSUE that voice SHALL go to RELEASING and voice_note_off SHALL pulse for it.
REQ-026 A note-off with no matching HELD voice SHALL produce no pulse and no state change.
REQ-027 voice_envelope_end[i] SHALL move voice i from RELEASING to FREE in any FSM state; in any other state it SHALL be ignored.
REQ-028 An ISSUE note-on to voice i in the same cycle as envelope_end[i] SHALL leave voice i HELD (issue wins).
REQ-029 panic sampled high in IDLE SHALL move all HELD voices to RELEASING and pulse voice_note_off for all of them in the next cycle.
REQ-030 panic does not abort an event already accepted: that event SHALL complete first, then panic applies.
REQ-031 voice_note SHALL retain the last loaded note after a voice goes FREE.

Reset
REQ-032 On reset_l low, asynchronously: FSM to IDLE, all voices FREE with age 0 and note 0.
REQ-033 On reset_l low, asynchronously: voice_note_on, voice_note_off, voice_active and steal SHALL be 0.
REQ-034 Reset mid-operation SHALL discard any accepted-but-unissued event, and no pulse SHALL follow reset release.
REQ-035 event_ready SHALL be 1 on the first cycle after reset release.

Verification (NUM_VOICES=4)
REQ-036 Note-on 60 from reset -> voice_note_on=0001 two cycles after acceptance, voice_active=0001, voice_note[0]=60.
REQ-037 Note-ons 60,62,64,65 then 67, no releases -> 67 steals voice 0 (largest age): steal=1, voice_note_on=0001.
REQ-038 Note-ons 60,62, then note-off 60, then note-on 70 -> voice 0 RELEASING, then 70 goes to voice 2 (FREE precedes RELEASING), steal=0.
REQ-039 Note-on 60, note-off 60, envelope_end[0] pulse -> voice_active=0000; a second note-off 60 produces no pulse.
REQ-040 Note-on 60 twice -> second event retriggers voice 0 (voice_note_on=0001), voice_active=0001.
REQ-041 Three voices HELD, then panic=1 -> voice_note_off=0111 for one cycle; event_ready=0 while panic is high.
